// File: rtl/param_rr_mux.sv
// param_rr_mux: N-channel, W-bit streaming multiplexer with valid/ready
// handshakes on every channel. The arbiter is either round-robin or fixed
// priority (lowest index wins). It drives a single registered output stage
// that can drain and refill in the same cycle.
module param_rr_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q,  out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] last_q,     last_d;

  logic [N-1:0]    grant;
  logic [SELW-1:0] gnt_idx;
  logic            gnt_found;
  logic [SELW-1:0] cand;
  logic [W-1:0]    gnt_data;
  logic            load_en;
  logic            xfer;

  // Arbitration: fixed priority scans from index 0. Round-robin scans from
  // last+1 and wraps modulo N. The first valid channel found gets the grant.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    grant     = '0;
    if (mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!gnt_found && in_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        cand = SELW'((32'(last_q) + k) % N);
        if (!gnt_found && in_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Data select from the one-hot grant. Only the granted slice is routed,
  // so in_data reaches nothing except the output register.
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  assign load_en  = !out_valid_q | out_ready;
  assign in_ready = grant & {N{load_en & ~rst}};
  // The grant only ever covers a valid channel, so any ready bit is a transfer.
  assign xfer     = |in_ready;

  // Output stage next state: load on transfer, clear valid when drained, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      last_d      = gnt_idx;
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers. last resets to N-1 so the first round-robin grant is channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
